// File: rtl/cnu.sv
// cnu - serial min-sum check node unit.
//
// Collects DC variable-to-check messages (one per handshake), tracking the
// two smallest magnitudes, the position of the smallest, every sign bit and
// the overall sign product. It then emits DC check-to-variable messages in
// the same edge order. Collect and emit never overlap.
//
// Optional feature: define CNU_OFFSET_EN for offset min-sum. The emitted
// magnitude then becomes max(m - OFFSET, 0). Without it, m is emitted as-is.
//
// Ports:
//   clk      - clock
//   rst      - asynchronous active-low reset
//   q_data   - incoming VNU message (two's complement, DATA_W bits)
//   q_valid  - q_data valid
//   q_ready  - block accepts q_data (high only while collecting)
//   r_data   - outgoing check message (registered)
//   r_valid  - r_data valid (registered)
//   r_ready  - downstream accepts r_data
//   r_last   - r_data is edge DC-1 of the block (registered)
module cnu #(
    parameter int DATA_W = 8,
    parameter int DC     = 6,
    parameter int IDX_W  = 3,
    parameter int OFFSET = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] q_data,
    input  logic              q_valid,
    output logic              q_ready,
    output logic [DATA_W-1:0] r_data,
    output logic              r_valid,
    input  logic              r_ready,
    output logic              r_last
);
    typedef enum logic [1:0] {IDLE, COLLECT, EMIT} state_t;

`ifdef CNU_OFFSET_EN
    localparam int OFF_EN = 1;
`else
    localparam int OFF_EN = 0;
`endif

    localparam logic [DATA_W-2:0] MAX_MAG  = '1;
    localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-2:0] OFF_M    = (DATA_W-1)'(OFFSET * OFF_EN);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DC - 1);

    state_t            state, state_nxt;
    logic [IDX_W-1:0]  cnt;
    logic [DC-1:0]     s;
    logic              p;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-2:0] min1, min2;

    logic              q_hs;
    logic [DATA_W-1:0] q_neg;
    logic [DATA_W-2:0] mag;
    logic [DC-1:0]     n_s;
    logic              n_p;
    logic [IDX_W-1:0]  n_idx;
    logic [DATA_W-2:0] n_min1, n_min2;
    logic [IDX_W-1:0]  out_j;
    logic              sel_s;
    logic [DATA_W-2:0] m, m_off;
    logic [DATA_W-1:0] out_msg;

    // FSM next state and q_ready
    always_comb begin
        state_nxt = state;
        q_ready   = 1'b0;
        case (state)
            IDLE:    state_nxt = COLLECT;
            COLLECT: begin
                q_ready = 1'b1;
                if (q_valid && cnt == LAST_IDX) state_nxt = EMIT;
            end
            EMIT:    if (r_ready && r_last) state_nxt = COLLECT;
            default: state_nxt = IDLE;
        endcase
    end

    assign q_hs = q_valid && q_ready;

    // Saturating magnitude: the most negative value maps to the largest
    // positive one so the later negation can never overflow.
    always_comb begin
        q_neg = -q_data;
        if (q_data == MOST_NEG)     mag = MAX_MAG;
        else if (q_data[DATA_W-1])  mag = q_neg[DATA_W-2:0];
        else                        mag = q_data[DATA_W-2:0];
    end

    // Post-update view of the block statistics. On the final collect
    // handshake this lets edge 0 be formed in the same cycle, so r_valid
    // rises right after the last q handshake.
    always_comb begin
        n_s    = s;
        n_p    = p;
        n_idx  = idx;
        n_min1 = min1;
        n_min2 = min2;
        if (q_hs) begin
            for (int k = 0; k < DC; k++)
                if (cnt == IDX_W'(k)) n_s[k] = q_data[DATA_W-1];
            n_p = p ^ q_data[DATA_W-1];
            // strict compare: a tie with min1 lands in min2
            if (mag < min1) begin
                n_min2 = min1;
                n_min1 = mag;
                n_idx  = cnt;
            end else if (mag < min2) begin
                n_min2 = mag;
            end
        end
    end

    // Message for the edge presented next: edge 0 when leaving COLLECT,
    // otherwise the edge after the current one.
    always_comb begin
        out_j = (state == EMIT) ? cnt + IDX_W'(1) : '0;
        sel_s = 1'b0;
        for (int k = 0; k < DC; k++)
            if (out_j == IDX_W'(k)) sel_s = n_s[k];
        m       = (out_j == n_idx) ? n_min2 : n_min1;
        m_off   = (m > OFF_M) ? m - OFF_M : '0;
        out_msg = (n_p ^ sel_s) ? -{1'b0, m_off} : {1'b0, m_off};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            s       <= '0;
            p       <= 1'b0;
            idx     <= '0;
            min1    <= MAX_MAG;
            min2    <= MAX_MAG;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == COLLECT && q_hs) begin
                s    <= n_s;
                p    <= n_p;
                idx  <= n_idx;
                min1 <= n_min1;
                min2 <= n_min2;
                if (cnt == LAST_IDX) begin
                    cnt     <= '0;
                    r_valid <= 1'b1;
                    r_data  <= out_msg;
                    r_last  <= 1'b0;
                end else begin
                    cnt <= cnt + IDX_W'(1);
                end
            end
            if (state == EMIT && r_valid && r_ready) begin
                if (r_last) begin
                    cnt     <= '0;
                    r_valid <= 1'b0;
                    r_last  <= 1'b0;
                    r_data  <= '0;
                    min1    <= MAX_MAG;
                    min2    <= MAX_MAG;
                    p       <= 1'b0;
                    idx     <= '0;
                end else begin
                    cnt    <= cnt + IDX_W'(1);
                    r_data <= out_msg;
                    r_last <= (cnt + IDX_W'(1) == LAST_IDX);
                end
            end
        end
    end
endmodule

// File: tb/tb_cnu.sv
module tb_cnu;
    localparam int DW = 8;
    localparam int DC = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] q_data = '0;
    logic          q_valid = 1'b0;
    logic          q_ready;
    logic [DW-1:0] r_data;
    logic          r_valid;
    logic          r_ready = 1'b0;
    logic          r_last;

    cnu #(.DATA_W(DW), .DC(DC), .IDX_W(3), .OFFSET(1)) dut (
        .clk(clk), .rst(rst),
        .q_data(q_data), .q_valid(q_valid), .q_ready(q_ready),
        .r_data(r_data), .r_valid(r_valid), .r_ready(r_ready), .r_last(r_last)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef logic [DC-1:0][DW-1:0] blk_t;
    typedef struct packed { blk_t q; blk_t r; } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic blk_t mk(input int a0, a1, a2, a3, a4, a5);
        blk_t b;
        b[0] = 8'(a0); b[1] = 8'(a1); b[2] = 8'(a2);
        b[3] = 8'(a3); b[4] = 8'(a4); b[5] = 8'(a5);
        return b;
    endfunction

    // Reference: each output is the smallest saturated magnitude among the
    // OTHER edges, signed by the product of the other edges' signs.
    function automatic blk_t model(input blk_t q);
        blk_t r;
        int off;
`ifdef CNU_OFFSET_EN
        off = 1;
`else
        off = 0;
`endif
        for (int j = 0; j < DC; j++) begin
            int mn = 127;
            int neg = 0;
            for (int k = 0; k < DC; k++) begin
                if (k != j) begin
                    int v = int'($signed(q[k]));
                    int a = (v == -128) ? 127 : (v < 0 ? -v : v);
                    if (a < mn) mn = a;
                    if (v < 0) neg = neg ^ 1;
                end
            end
            mn = (mn > off) ? mn - off : 0;
            r[j] = 8'(neg ? -mn : mn);
        end
        return r;
    endfunction

    task automatic send(input blk_t q, input int gap);
        for (int k = 0; k < DC; k++) begin
            int t = 0;
            for (int g = 0; g < gap; g++) begin
                q_valid = 1'b0;
                @(negedge clk);
                chk("q_ready_gap", 32'(q_ready), 32'd1);
            end
            q_valid = 1'b1;
            q_data  = q[k];
            while (!q_ready && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (t >= 50) chk("q_ready_timeout", 32'(q_ready), 32'd1);
            @(negedge clk);
        end
        q_valid = 1'b0;
    endtask

    task automatic recv(input blk_t exp, input int stall_j, input int stall_n,
                        input bit rnd, input int stop_after);
        int j = 0;
        int stalled = 0;
        int cyc = 0;
        while (j < DC && j < stop_after) begin
            if (cyc >= 500) begin
                chk("recv_timeout", 32'(j), 32'(DC));
                break;
            end
            chk("r_valid", 32'(r_valid), 32'd1);
            chk("r_data", 32'(r_data), 32'(exp[j]));
            chk("r_last", 32'(r_last), 32'(j == DC - 1));
            if ((j == stall_j && stalled < stall_n) || (rnd && $urandom_range(3) == 0)) begin
                r_ready = 1'b0;
                if (j == stall_j) stalled++;
            end else begin
                r_ready = 1'b1;
                j++;
            end
            @(negedge clk);
            cyc++;
        end
        if (j == DC) begin
            chk("r_valid_drop", 32'(r_valid), 32'd0);
            chk("q_ready_after", 32'(q_ready), 32'd1);
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_q_ready", 32'(q_ready), 32'd0);
        chk("rst_r_valid", 32'(r_valid), 32'd0);
        chk("rst_r_last", 32'(r_last), 32'd0);
        chk("rst_r_data", 32'(r_data), 32'd0);
    endtask

    vec_t tbl[6];

    initial begin
        blk_t s1q, s2q;
        s1q = mk(5, -3, 7, 2, -9, 4);
        s2q = mk(-128, 100, 100, 100, 100, 100);
        tbl[0].q = s1q;
        tbl[1].q = s2q;
        tbl[2].q = mk(1, -1, 5, 5, 5, 5);
        tbl[3].q = mk(10, 20, 30, 40, 50, 60);
        tbl[4].q = mk(-1, -1, -1, -1, -1, -1);
        tbl[5].q = mk(0, -128, 3, 4, 5, 6);
`ifdef CNU_OFFSET_EN
        tbl[0].r = mk(1, -1, 1, 2, -1, 1);
        tbl[1].r = mk(99, -99, -99, -99, -99, -99);
        tbl[2].r = mk(0, 0, 0, 0, 0, 0);
        tbl[3].r = mk(19, 9, 9, 9, 9, 9);
        tbl[4].r = mk(0, 0, 0, 0, 0, 0);
        tbl[5].r = mk(-2, 0, 0, 0, 0, 0);
`else
        tbl[0].r = mk(2, -2, 2, 3, -2, 2);
        tbl[1].r = mk(100, -100, -100, -100, -100, -100);
        tbl[2].r = mk(-1, 1, -1, -1, -1, -1);
        tbl[3].r = mk(20, 10, 10, 10, 10, 10);
        tbl[4].r = mk(-1, -1, -1, -1, -1, -1);
        tbl[5].r = mk(-3, 0, 0, 0, 0, 0);
`endif

        // reset state
        repeat (2) @(negedge clk);
        chk_reset_outputs();
        rst = 1'b1;
        chk("idle_q_ready", 32'(q_ready), 32'd0);
        @(negedge clk);
        chk("collect_q_ready", 32'(q_ready), 32'd1);

        // table vectors, back-to-back, r_ready high
        for (int i = 0; i < 6; i++) begin
            send(tbl[i].q, 0);
            recv(tbl[i].r, -1, 0, 1'b0, DC);
        end

        // backpressure on edge 2 for 3 cycles
        send(s1q, 0);
        recv(tbl[0].r, 2, 3, 1'b0, DC);

        // 2 idle cycles between q beats
        send(s1q, 2);
        recv(tbl[0].r, -1, 0, 1'b0, DC);

        // reset mid-emit, then a clean block
        send(s1q, 0);
        recv(tbl[0].r, -1, 0, 1'b0, 3);
        rst = 1'b0;
        #1;
        chk_reset_outputs();
        @(negedge clk);
        rst = 1'b1;
        chk("rel_q_ready0", 32'(q_ready), 32'd0);
        @(negedge clk);
        chk("rel_q_ready1", 32'(q_ready), 32'd1);
        send(s2q, 0);
        recv(tbl[1].r, -1, 0, 1'b0, DC);

        // random blocks against the reference model
        for (int b = 0; b < 40; b++) begin
            blk_t q;
            for (int k = 0; k < DC; k++) begin
                if ($urandom_range(7) == 0) q[k] = 8'h80;
                else q[k] = 8'($urandom_range(255));
            end
            send(q, int'($urandom_range(2)));
            recv(model(q), -1, 0, 1'b1, DC);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cnu.md
# cnu

Serial min-sum check node unit for the LDPC decoder. It consumes the variable-to-check messages produced by the variable node units, one message per cycle, for a check of degree `DC`. It then returns the check-to-variable messages serially in the same edge order, and those messages feed the VNU `r` inputs. All messages are two's-complement `DATA_W`-bit LLRs, the same format the VNU uses.

## Interface
Parameters:
- `DATA_W`, default 8: message width, two's complement.
- `DC`, default 6: check-node degree, i.e. messages per block. Must be ≥ 2.
- `IDX_W`, default 3: edge index width. Must satisfy 2^`IDX_W` ≥ `DC`.
- `OFFSET`, default 1: offset subtracted from magnitudes. Used only with `CNU_OFFSET_EN`.

Ports:
- `clk`, input, 1: clock.
- `rst`, input, 1: reset. One clock; reset is asynchronous and active-low.
- `q_data`, input, `DATA_W`: incoming VNU message.
- `q_valid`, input, 1: `q_data` is valid.
- `q_ready`, output, 1: the block accepts `q_data`.
- `r_data`, output, `DATA_W`: outgoing check message.
- `r_valid`, output, 1: `r_data` is valid.
- `r_ready`, input, 1: the downstream stage accepts `r_data`.
- `r_last`, output, 1: marks the final message (edge `DC`-1) of a block.

## Operation
- FSM states: IDLE, COLLECT, EMIT. The reset state is IDLE.
- IDLE always moves to COLLECT on the next cycle.
- COLLECT:
  - `q_ready`=1.
  - On each handshake (`q_valid`&`q_ready`), at input counter k:
    - mag = |q_data|, saturated so that -2^(`DATA_W`-1) gives 2^(`DATA_W`-1)-1.
    - Store sign bit s[k] = `q_data`[`DATA_W`-1].
    - Update sign product P ^= s[k].
  - Min update:
    - If mag < min1: min2←min1, min1←mag, idx←k.
    - Else if mag < min2: min2←mag.
    - A tie with min1 therefore goes to min2.
  - When k=`DC`-1 is accepted, the counter clears and the state moves to EMIT.
- EMIT:
  - `q_ready`=0.
  - At output counter j, magnitude m = (j==idx) ? min2 : min1.
  - Sign = P ^ s[j].
  - `r_data` = sign ? -m : m. A zero magnitude always emits 0.
  - `r_last`=(j==`DC`-1).
  - On each handshake (`r_valid`&`r_ready`), j increments.
  - On the handshake with `r_last`=1: move to COLLECT, clear min1/min2 to 2^(`DATA_W`-1)-1, clear P and idx to 0.
- Negation never overflows, because m ≤ 2^(`DATA_W`-1)-1.
- There is no overlap between collect and emit. A block takes at least 2·`DC` cycles.

## Timing
- Reset values:
  - `q_ready`=0, `r_valid`=0, `r_last`=0, `r_data`=0.
  - Counters, s, P and idx are 0.
  - min1 and min2 are 2^(`DATA_W`-1)-1.
- `q_ready` rises one cycle after `rst` deasserts (IDLE→COLLECT).
- `r_data`, `r_valid` and `r_last` are registered.
- `r_valid` rises the cycle after the last `q` handshake, with j=0 already presented.
- Backpressure: while `r_valid`=1 and `r_ready`=0, `r_data` and `r_last` hold stable and j does not advance.
- With `r_ready` held high, one message is emitted per cycle.
- `r_valid` drops the cycle after the `r_last` handshake, and `q_ready`=1 in that same cycle.
- Gaps in `q_valid` stall the collection only; the result is unaffected.
- `q_valid` during EMIT is ignored. The upstream stage holds the data because `q_ready`=0.
- `rst` asserted in any state returns every register to its reset value immediately. A partial block is discarded.

## Configuration
- `CNU_OFFSET_EN` defined: offset min-sum. Emitted magnitude is max(m - `OFFSET`, 0), computed when min1/min2 are selected. This adds no latency.
- Not defined: plain min-sum, m emitted unmodified. The `OFFSET` parameter is unused.

## Test plan
1. `DATA_W`=8, `DC`=6, q = 5,-3,7,2,-9,4 back-to-back with `r_ready`=1 → r = +2,-2,+2,+3,-2,+2. `r_last` is set on the 6th message only. First `r_valid` is one cycle after the 6th `q` handshake.
2. q = -128,100,100,100,100,100 (saturation and tie) → r = +100,-100,-100,-100,-100,-100.
3. Scenario 1 with `r_ready` low for 3 cycles while j=2 is presented → `r_data`=+2 is held stable and `r_valid` stays 1. The output sequence is unchanged.
4. Scenario 1 with 2 idle cycles between each `q_valid` → identical r sequence. `q_ready` stays 1 throughout COLLECT.
5. Assert `rst` after 3 outputs of scenario 1 → all outputs read 0 immediately. `q_ready`=1 one cycle after release. A fresh scenario-2 block then produces exactly the scenario-2 result.
6. With `CNU_OFFSET_EN`, `OFFSET`=1, scenario 1 → r = +1,-1,+1,+2,-1,+1. Also drive q = 1,-1,5,5,5,5 → r = 0,0,0,0,0,0.
